// File: rtl/hb_up_serializer_pkg.sv
// Shared definitions for the upstream heartbeat serializer: code map, chunk geometry, word layout.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hb_up_serializer_pkg;

  // Upstream word geometry: {code, payload}
  localparam int Ncode  = 4;
  localparam int Nchunk = 16;

  // Heartbeat chunk k is tagged HB_CODE_BASE+k; codes 1..NChunks belong to the heartbeat,
  // the other upstream producers use codes outside that range.
  localparam logic [Ncode-1:0] HB_CODE_BASE = 4'h1;

  // Number of payload chunks needed to carry an ntime-bit value.
  function automatic int n_chunks(input int ntime, input int nchunk);
    return (ntime + nchunk - 1) / nchunk;
  endfunction

  typedef struct packed {
    logic [Ncode-1:0]  code;
    logic [Nchunk-1:0] payload;
  } hb_word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } hb_state_e;

endpackage

// File: rtl/hb_up_serializer.sv
// Upstream heartbeat transmitter: snapshots time_elapsed on a pulse and sends it LSB-chunk first.
// Latency: out_v rises 1 cycle after the accepted pulse; one word per cycle while out_a is high.
// Backpressure: out_v/out_d hold until acked; one pulse queued while busy, further pulses dropped and counted.
module hb_up_serializer
  import hb_up_serializer_pkg::*;
#(
  parameter int Ntime = 48,
  parameter int Ndrop = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    send_HB_up_pulse,
  input  logic [Ntime-1:0]        time_elapsed,
  output logic                    out_v,
  input  logic                    out_a,
  output logic [Ncode+Nchunk-1:0] out_d,
  output logic                    busy,
  output logic [Ndrop-1:0]        dropped_count
);

  localparam int NCHUNKS = n_chunks(Ntime, Nchunk);
  localparam int SNAP_W  = NCHUNKS * Nchunk;
  localparam int CW      = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNKS - 1);

  hb_state_e         state_q, state_d;
  logic [CW-1:0]     chunk_q, chunk_d;
  logic [SNAP_W-1:0] active_q, active_d;
  logic [SNAP_W-1:0] pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [Ndrop-1:0]  drop_q, drop_d;

  logic              accept;
  logic              ack;
  logic              last_chunk;
  logic              drop_inc;
  logic [SNAP_W-1:0] time_ext;
  hb_word_t          word;

  // Zero-extend the wall clock up to a whole number of chunks.
  assign time_ext   = SNAP_W'(time_elapsed);
  assign accept     = enable & send_HB_up_pulse;
  assign ack        = (state_q == ST_SEND) & out_a;
  assign last_chunk = (chunk_q == LAST_CHUNK);

  // Next-state logic: packet sequencing, one-deep pending slot, drop accounting.
  always_comb begin
    state_d    = state_q;
    chunk_d    = chunk_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    drop_d     = drop_q;
    drop_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          active_d = time_ext;
          chunk_d  = '0;
          state_d  = ST_SEND;
        end
      end

      ST_SEND: begin
        if (ack && last_chunk) begin
          // Packet boundary: start the next packet with no bubble if anything is queued.
          chunk_d = '0;
          if (pend_vld_q) begin
            active_d = pend_q;
            if (accept) begin
              pend_d = time_ext;     // slot freed and refilled on the same edge
            end else begin
              pend_vld_d = 1'b0;
            end
          end else if (accept) begin
            active_d = time_ext;     // empty slot is bypassed
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (ack) begin
            chunk_d = chunk_q + 1'b1;
          end
          if (accept) begin
            if (!pend_vld_q) begin
              pend_d     = time_ext;
              pend_vld_d = 1'b1;
            end else begin
              drop_inc = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Saturating drop counter.
    if (drop_inc && (drop_q != {Ndrop{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  // State registers; reset abandons any packet in flight and the pending slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      chunk_q    <= '0;
      active_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      chunk_q    <= chunk_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      drop_q     <= drop_d;
    end
  end

  // Output word selected by the chunk index; forced to zero while nothing is offered.
  always_comb begin
    word.code    = HB_CODE_BASE + Ncode'(chunk_q);
    word.payload = active_q[chunk_q * Nchunk +: Nchunk];
  end

  assign out_v         = (state_q == ST_SEND);
  assign out_d         = out_v ? word : '0;
  assign busy          = out_v | pend_vld_q;
  assign dropped_count = drop_q;

endmodule
